// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional build macro FETCH_PERF_EN adds performance counters to if_fetch_unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam int          DEFAULT_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch stage; master = fetch unit, slave = memory.
interface if_fetch_unit_if;

    // imem_req/imem_addr form a one-cycle request (no ready: memory always accepts).
    // Each request earns exactly one imem_rvalid pulse, in request order, >=1 cycle later.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetch entries with flush; head is always visible.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
        head    = mem[rd_ptr];
    end

    // Storage is reset so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads, presents {pc, ins} to IF/ID.
// Define FETCH_PERF_EN to add saturating stall/redirect/drop counters.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_out,
    output logic [31:0]            ins,
    output logic                   ins_valid,
    output fetch_state_e           state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_stall_cyc,
    output logic [31:0]            perf_redirect_cnt,
    output logic [31:0]            perf_drop_cnt
`endif
);

    localparam int               CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]      DEPTH_L = (CW+1)'(BUF_DEPTH);

    logic [CW-1:0]  out_cnt;
    logic [CW-1:0]  occ_cnt;
    fetch_entry_t   addr_head;
    fetch_entry_t   addr_din;
    fetch_entry_t   buf_head;
    fetch_entry_t   buf_din;
    logic           issue;
    logic           resp_valid;
    logic           discard;
    logic           buf_push;
    logic           buf_pop;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_pc_n;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  drop_n;
    fetch_state_e   state_n;

    always_comb begin
        resp_valid     = imem.imem_rvalid && (out_cnt != '0);
        issue          = rst_n && !redirect &&
                         (({1'b0, out_cnt} + {1'b0, occ_cnt}) < DEPTH_L);
        discard        = redirect || (state == DRAIN);
        buf_push       = resp_valid && !discard;
        ins_valid      = (occ_cnt != '0);
        buf_pop        = ins_valid && !stall && !redirect;
        pc_out         = buf_head.pc;
        ins            = ins_valid ? buf_head.ins : NOP_INSTR;
        imem.imem_req  = issue;
        imem.imem_addr = fetch_pc;
        addr_din       = '{pc: fetch_pc, ins: NOP_INSTR};
        // Address-side ins is always NOP (zero), so the OR only carries imem_rdata.
        buf_din        = '{pc: addr_head.pc, ins: imem.imem_rdata | addr_head.ins};
    end

    // Addresses of outstanding requests; responses pair with them purely by order.
    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_addr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .pop   (resp_valid),
        .flush (1'b0),
        .din   (addr_din),
        .head  (addr_head),
        .count (out_cnt)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect),
        .din   (buf_din),
        .head  (buf_head),
        .count (occ_cnt)
    );

    // Every request still outstanding at a redirect is stale; one returning now is dropped too.
    always_comb begin
        fetch_pc_n = fetch_pc;
        drop_n     = drop_cnt;
        state_n    = state;
        if (redirect) begin
            fetch_pc_n = redirect_pc;
            drop_n     = out_cnt - CW'(resp_valid);
        end else begin
            if (issue) begin
                fetch_pc_n = next_fetch_pc(fetch_pc);
            end
            if (resp_valid && (state == DRAIN)) begin
                drop_n = drop_cnt - CW'(1);
            end
        end
        state_n = (drop_n != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drop_cnt <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            drop_cnt <= drop_n;
            fetch_pc <= fetch_pc_n;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc    <= '0;
            perf_redirect_cnt <= '0;
            perf_drop_cnt     <= '0;
        end else begin
            if (stall && ins_valid && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (redirect && (perf_redirect_cnt != '1)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
            if (resp_valid && discard && (perf_drop_cnt != '1)) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model and an expected-fetch queue.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          DEPTH  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic [31:0]  pc_out;
    logic [31:0]  ins;
    logic         ins_valid;
    fetch_state_e state;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_stall_cyc;
    logic [31:0]  perf_redirect_cnt;
    logic [31:0]  perf_drop_cnt;
`endif

    if_fetch_unit_if imem ();

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .pc_out      (pc_out),
        .ins         (ins),
        .ins_valid   (ins_valid),
        .state       (state)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cyc    (perf_stall_cyc),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          issue;
        bit          stale;
    } mreq_t;

    mreq_t        mem_q[$];
    logic [63:0]  exp_q[$];
    int           cyc;
    int           lat;
    int           stale_inflight;
    int           arrived;
    logic [31:0]  fpc_m;
    bit           cur_act;
    bit           cur_stale;
    bit           cur_orphan;
    int           total_checks;
    int           passed_checks;
    int           failed_checks;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0f0f_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_checks++;
        assert (obs === expv) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: check mid-cycle, update the model, then drive memory just after the edge.
    task automatic tick();
        logic  exp_req;
        int    used;
        mreq_t m;
        @(negedge clk);
        used    = exp_q.size() + stale_inflight;
        exp_req = rst_n && !redirect && (used < DEPTH);
        chk("imem_req", 64'(imem.imem_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", 64'(imem.imem_addr), 64'(fpc_m));
        chk("ins_valid", 64'(ins_valid), 64'(arrived > 0));
        if (arrived > 0) chk("head", {pc_out, ins}, exp_q[0]);
        else             chk("ins_nop", 64'(ins), 64'(NOP_INSTR));
        chk("fsm_state", 64'(state), 64'((stale_inflight != 0) ? DRAIN : RUN));
        if (arrived > 0 && !stall && !redirect) begin
            void'(exp_q.pop_front());
            arrived--;
        end
        if (rst_n && redirect) begin
            exp_q.delete();
            arrived = 0;
            foreach (mem_q[i]) begin
                if (!mem_q[i].stale) begin
                    mem_q[i].stale = 1'b1;
                    stale_inflight++;
                end
            end
            if (cur_act && !cur_stale && !cur_orphan) begin
                cur_stale = 1'b1;
                stale_inflight++;
            end
            fpc_m = redirect_pc;
        end else if (exp_req) begin
            exp_q.push_back({fpc_m, mem_word(fpc_m)});
            mem_q.push_back('{addr: fpc_m, issue: cyc, stale: 1'b0});
            fpc_m = fpc_m + 32'd4;
        end
        @(posedge clk);
        #1;
        if (cur_act && rst_n && !cur_orphan) begin
            if (cur_stale) stale_inflight--;
            else           arrived++;
        end
        cur_act    = 1'b0;
        cur_stale  = 1'b0;
        cur_orphan = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        cyc++;
        if (rst_n && mem_q.size() > 0 && cyc >= mem_q[0].issue + lat) begin
            m = mem_q.pop_front();
            cur_act   = 1'b1;
            cur_stale = m.stale;
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = mem_word(m.addr);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        mem_q.delete();
        stale_inflight = 0;
        arrived        = 0;
        cur_act        = 1'b0;
        cur_stale      = 1'b0;
        cur_orphan     = 1'b0;
        fpc_m          = RST_PC;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
    endtask

    task automatic release_reset(input bit orphan);
        rst_n = 1'b1;
        cyc   = 0;
        fpc_m = RST_PC;
        if (orphan) begin
            cur_act    = 1'b1;
            cur_orphan = 1'b1;
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_imem_req", 64'(imem.imem_req), 64'(0));
        chk("rst_ins_valid", 64'(ins_valid), 64'(0));
        chk("rst_ins", 64'(ins), 64'(0));
        chk("rst_pc_out", 64'(pc_out), 64'(0));
        chk("rst_state", 64'(state), 64'(RUN));
`ifdef FETCH_PERF_EN
        chk("rst_perf_stall", 64'(perf_stall_cyc), 64'(0));
        chk("rst_perf_redirect", 64'(perf_redirect_cnt), 64'(0));
        chk("rst_perf_drop", 64'(perf_drop_cnt), 64'(0));
`endif
        clear_model();
        repeat (2) tick();
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        while (!ins_valid && i < 32) begin
            tick();
            i++;
        end
        if (!ins_valid) chk({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen_wrap;
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        lat = 1;
        cyc = 0;
        clear_model();

        // Reset state
        repeat (3) tick();
        chk("reset_pc_out", 64'(pc_out), 64'(0));
        chk("reset_ins", 64'(ins), 64'(0));
        chk("reset_ins_valid", 64'(ins_valid), 64'(0));
        chk("reset_imem_req", 64'(imem.imem_req), 64'(0));

        // 1-cycle memory: sequential addresses, first instruction in cycle 2
        release_reset(1'b0);
        chk("t1_addr0", 64'(imem.imem_addr), 64'(32'h0000_3000));
        tick();
        chk("t1_addr1", 64'(imem.imem_addr), 64'(32'h0000_3004));
        tick();
        chk("t1_valid_c2", 64'(ins_valid), 64'(1));
        chk("t1_pc_c2", 64'(pc_out), 64'(32'h0000_3000));
        tick();

        // Stall for 3 cycles while 0x3004 is presented
        stall = 1'b1;
        chk("t2_pc_start", 64'(pc_out), 64'(32'h0000_3004));
        tick();
        tick();
        chk("t2_req_full", 64'(imem.imem_req), 64'(0));
        tick();
        chk("t2_pc_held", 64'(pc_out), 64'(32'h0000_3004));
        chk("t2_ins_held", 64'(ins), 64'(mem_word(32'h0000_3004)));
        stall = 1'b0;
        repeat (4) tick();

        // Address wrap past the top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect  = 1'b0;
        seen_wrap = 1'b0;
        for (int i = 0; i < 12 && !seen_wrap; i++) begin
            if (imem.imem_req && fpc_m == 32'h0) begin
                chk("t5_wrap_addr", 64'(imem.imem_addr), 64'(0));
                seen_wrap = 1'b1;
            end
            tick();
        end
        if (!seen_wrap) chk("t5_wrap_timeout", 64'(0), 64'(1));
        repeat (2) tick();

        // Async reset in the middle of a burst
        async_reset();

        // 3-cycle memory, redirect with two requests in flight, orphan response at release
        lat = 3;
        release_reset(1'b1);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4000;
        tick();
        redirect = 1'b0;
        chk("t3_valid_after", 64'(ins_valid), 64'(0));
        chk("t3_drain", 64'(state), 64'(DRAIN));
        wait_valid("t3_wait");
        chk("t3_first_pc", 64'(pc_out), 64'(32'h0000_4000));
`ifdef FETCH_PERF_EN
        chk("t3_perf_redirect", 64'(perf_redirect_cnt), 64'(1));
        chk("t3_perf_drop", 64'(perf_drop_cnt), 64'(2));
        chk("t3_perf_stall", 64'(perf_stall_cyc), 64'(0));
`endif

        // Redirect and stall together: flush wins
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_6000;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("t4_flushed", 64'(ins_valid), 64'(0));
        wait_valid("t4_wait");
        chk("t4_first_pc", 64'(pc_out), 64'(32'h0000_6000));
`ifdef FETCH_PERF_EN
        chk("t4_perf_stall", 64'(perf_stall_cyc), 64'(1));
        chk("t4_perf_redirect", 64'(perf_redirect_cnt), 64'(2));
`endif
        repeat (6) tick();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
